// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one multi-cycle FP unit between two requesters,
// with a done-timeout watchdog and a tagged valid/ready response.
module fpu_share_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int OPW = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [31:0]    req0_rs1_data,
    input  logic [31:0]    req0_rs2_data,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [31:0]    req1_rs1_data,
    input  logic [31:0]    req1_rs2_data,
    output logic           fu_start,
    output logic [OPW-1:0] fu_op,
    output logic [31:0]    fu_a,
    output logic [31:0]    fu_b,
    input  logic           fu_done,
    input  logic [31:0]    fu_result,
    input  logic [4:0]     fu_flags,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [31:0]    rsp_result,
    output logic [5:0]     rsp_flags,
    output logic           busy,
    output logic [15:0]    op_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic rr;
    logic grant1;
    logic [TW-1:0] timer;
    // rr high means requester 1 wins when both are valid
    always_comb begin
        grant1     = req1_valid & (~req0_valid | rr);
        req0_ready = (state == IDLE) & req0_valid & ~grant1;
        req1_ready = (state == IDLE) & grant1;
        fu_start   = state == ISSUE;
        rsp_valid  = state == RESP;
        busy       = state != IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rr         <= 1'b0;
            rsp_id     <= 1'b0;
            timer      <= '0;
            fu_op      <= '0;
            fu_a       <= '0;
            fu_b       <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            op_count   <= '0;
        end else begin
            unique case (state)
                IDLE: if (req0_ready | req1_ready) begin
                    rsp_id <= grant1;
                    fu_op  <= grant1 ? req1_op : req0_op;
                    fu_a   <= grant1 ? req1_rs1_data : req0_rs1_data;
                    fu_b   <= grant1 ? req1_rs2_data : req0_rs2_data;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: if (fu_done) begin
                    rsp_result <= fu_result;
                    rsp_flags  <= {1'b0, fu_flags};
                    state      <= RESP;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_result <= 32'h7FC0_0000;
                    rsp_flags  <= 6'b100000;
                    state      <= RESP;
                end else begin
                    timer <= timer + 1'b1;
                end
                RESP: if (rsp_ready) begin
                    op_count <= op_count + 16'd1;
                    rr       <= ~rsp_id;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Controller that shares one multi-cycle floating-point functional unit (FU) between two requesters, e.g. the decode/issue path and a writeback-retry path of cpu_module.
- Round-robin arbitration over two request ports, one operation in flight at a time.
- Issues operands to the FU with a start pulse and waits for done, with a timeout watchdog.
- Returns the result with a valid/ready handshake tagged by requester id.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent in WAIT without fu_done before an operation is aborted (min 2)
OPW, 2, width of operation code

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when high with valid
req0_op  input  OPW  requester 0 op code (passed through to FU)
req0_rs1_data  input  32  requester 0 operand A (IEEE-754 single)
req0_rs2_data  input  32  requester 0 operand B
req1_valid / req1_ready / req1_op / req1_rs1_data / req1_rs2_data  same as requester 0
fu_start  output  1  one-cycle start pulse to FU
fu_op  output  OPW  latched op, stable from ISSUE through WAIT
fu_a  output  32  latched operand A, stable ISSUE..WAIT
fu_b  output  32  latched operand B, stable ISSUE..WAIT
fu_done  input  1  FU result valid (single-cycle pulse)
fu_result  input  32  FU result, valid with fu_done
fu_flags  input  5  FU exception flags {NV,DZ,OF,UF,NX}, valid with fu_done
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that owns the response
rsp_result  output  32  result
rsp_flags  output  6  {TIMEOUT, NV,DZ,OF,UF,NX}
busy  output  1  high in any state other than IDLE
op_count  output  16  completed responses (handshaken), wraps 0xFFFF->0

Behaviour:
- Reset: synchronous, active-high. Only clock and reset; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, rr pointer favours requester 0, timer 0, op_count 0.
- States and transitions:
  - IDLE:
    - Grant: if only one reqN_valid, grant N; if both, grant the requester the rr pointer favours.
    - reqN_ready = 1 combinationally only for the granted N; the other ready is 0.
    - No request: both ready 0, stay in IDLE.
    - On valid&ready: latch op, rs1, rs2, id; go to ISSUE.
  - ISSUE:
    - fu_start = 1 for exactly this cycle; fu_op/fu_a/fu_b driven from latches.
    - Clear timer; go to WAIT. fu_done is ignored in ISSUE.
  - WAIT:
    - Timer increments each cycle.
    - If fu_done: latch fu_result, {0, fu_flags}; go to RESP.
    - Else if timer == TIMEOUT_CYCLES-1: latch result 0x7FC00000 (qNaN), rsp_flags = 6'b100000; go to RESP.
    - fu_done has priority over timeout in the same cycle.
  - RESP:
    - rsp_valid = 1; rsp_id/result/flags held stable until rsp_ready.
    - On rsp_valid&rsp_ready: op_count += 1, rr pointer favours the other requester (relative to rsp_id), go to IDLE.
- Latency: accept at edge T → fu_start high cycle T+1 → earliest fu_done sampled T+2 → rsp_valid T+3. Minimum 4 cycles per op with rsp_ready held high.
- Ready is never asserted outside IDLE; no new accept in the cycle a response handshakes (IDLE is entered on the next edge).
- fu_done outside WAIT is ignored, including a late done after a timeout.
- Operands are passed unmodified; no FP arithmetic in this block.
- Reset mid-operation: abort the in-flight op, drop any pending response, return all outputs to reset values on the next edge. A subsequent stale fu_done is ignored.
- op_count wraps silently.

Test Plan:
- Single op: req0 op=0 with rs1=0xBE800000, rs2=0xBE700000; FU model returns 0xBEF80000, flags 0 after 3 cycles → fu_start one pulse with fu_a/fu_b as given; rsp_valid with rsp_id=0, rsp_result=0xBEF80000, rsp_flags=0; op_count=1.
- Contention: both valid from reset → req0 granted first, req1 granted next (ready only after req0 response handshakes); then with both still valid, req0 again → strict alternation 0,1,0,1.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid and payload stable; both reqN_ready=0; busy=1 throughout.
- Timeout: FU never asserts done, TIMEOUT_CYCLES=8 → rsp_result=0x7FC00000, rsp_flags=6'b100000 after exactly 8 WAIT cycles. A later fu_done pulse in IDLE causes no response.
- Flags/priority: FU asserts done with flags 5'b00001 exactly on the timeout cycle → done wins, rsp_flags=6'b000001.
- Reset mid-WAIT: assert reset for 1 cycle → next edge: busy=0, fu_start=0, rsp_valid=0, op_count=0; new request accepted normally afterwards.
